// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: states, opcodes,
// ALU control codes, instruction field layout and decode helpers.
package alu_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_MOV  = 3'b101;
  localparam logic [2:0] OP_ILL  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  localparam int OP_MSB = 7;
  localparam int OP_LSB = 5;
  localparam int RD_MSB = 4;
  localparam int RD_LSB = 3;
  localparam int RS_MSB = 2;
  localparam int RS_LSB = 1;

  // Latched instruction, bit 0 of the word is dropped.
  typedef struct packed {
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
  } fields_t;

  function automatic logic is_alu(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND) || (op == OP_OR)  ||
           (op == OP_XOR);
  endfunction

  function automatic logic [2:0] alu_code(
    input logic [2:0] op
  );
    logic [2:0] c;
    c = ALU_ADD;
    unique case (1'b1)
      (op == OP_SUB): c = ALU_SUB;
      (op == OP_AND): c = ALU_AND;
      (op == OP_OR):  c = ALU_OR;
      (op == OP_XOR): c = ALU_XOR;
      default:        c = ALU_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_sequencer_regfile4x8.sv
// Register file: one sync write port, two comb read ports, debug read.
// Ports: clk, reset, we/waddr/wdata, ra1/rd1, ra2/rd2, dbg_sel/dbg_data.
module regfile4x8 #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    ra1,
  output logic [WIDTH-1:0] rd1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd2,
  input  logic [AW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] mem_q [NREGS];
  logic [WIDTH-1:0] mem_d [NREGS];

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd1      = mem_q[ra1];
  assign rd2      = mem_q[ra2];
  assign dbg_data = mem_q[dbg_sel];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer feeding an external ALU from a 4x8 regfile.
// Ports: instr handshake, direct load, ALU ctrl/operands/result, status, debug read.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [7:0]       instr,
  output logic             instr_ready,
  input  logic             ld_en,
  input  logic [1:0]       ld_sel,
  input  logic [WIDTH-1:0] ld_data,
  output logic [2:0]       ALUctrlbits,
  output logic [WIDTH-1:0] data1,
  output logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] result,
  input  logic             zero,
  output logic             done,
  output logic             err,
  output logic             zflag,
  output logic             halted,
  input  logic [1:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  state_t           state_q, state_d;
  fields_t          instr_q, instr_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zs_q, zs_d;
  logic             zflag_q, zflag_d;
  logic             err_q, err_d;

  logic             we;
  logic [1:0]       waddr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rd1, rd2;

  // Reserved instruction bit, intentionally ignored.
  logic unused_instr_bit;
  assign unused_instr_bit = instr[0];

  regfile4x8 #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_rf (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .ra1      (instr_q.rd),
    .rd1      (rd1),
    .ra2      (instr_q.rs),
    .rd2      (rd2),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    ctrl_d  = ctrl_q;
    res_d   = res_q;
    zs_d    = zs_q;
    zflag_d = zflag_q;
    err_d   = 1'b0;
    we      = 1'b0;
    waddr   = ld_sel;
    wdata   = ld_data;
    unique case (state_q)
      S_IDLE: begin
        // Load lands at this edge, so DECODE sees it.
        we = ld_en;
        if (instr_valid) begin
          instr_d = fields_t'(instr[7:1]);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          (instr_q.op == OP_ILL): begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
          (instr_q.op == OP_HALT): begin
            state_d = S_HALT;
          end
          default: begin
            // Operands only move when they will be used,
            // so the ALU-facing outputs hold otherwise.
            opa_d = rd1;
            opb_d = rd2;
            if (is_alu(instr_q.op)) begin
              ctrl_d = alu_code(instr_q.op);
            end
            state_d = S_EXEC;
          end
        endcase
      end
      S_EXEC: begin
        res_d   = result;
        zs_d    = zero;
        state_d = S_WB;
      end
      S_WB: begin
        we    = 1'b1;
        waddr = instr_q.rd;
        if (is_alu(instr_q.op)) begin
          wdata   = res_q;
          zflag_d = zs_q;
        end else begin
          wdata = opb_q;
        end
        state_d = S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      ctrl_q  <= ALU_ADD;
      res_q   <= '0;
      zs_q    <= 1'b0;
      zflag_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      ctrl_q  <= ctrl_d;
      res_q   <= res_d;
      zs_q    <= zs_d;
      zflag_q <= zflag_d;
      err_q   <= err_d;
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign done        = (state_q == S_WB);
  assign halted      = (state_q == S_HALT);
  assign err         = err_q;
  assign zflag       = zflag_q;
  assign ALUctrlbits = ctrl_q;
  assign data1       = opa_q;
  assign data2       = opb_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU.
// Scoreboard of writebacks checked against the debug read port.
module tb_alu_sequencer;

  logic       clk;
  logic       reset;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic       ld_en;
  logic [1:0] ld_sel;
  logic [7:0] ld_data;
  logic [2:0] ALUctrlbits;
  logic [7:0] data1, data2;
  logic [7:0] result;
  logic       zero;
  logic       done, err, zflag, halted;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;

  typedef struct {
    logic [1:0] rd;
    logic [7:0] val;
    logic       z;
  } sb_t;

  sb_t        sb[$];
  logic [7:0] rm [4];
  logic       zm;
  int         n_cmp;
  int         n_bad;

  alu_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .ld_en       (ld_en),
    .ld_sel      (ld_sel),
    .ld_data     (ld_data),
    .ALUctrlbits (ALUctrlbits),
    .data1       (data1),
    .data2       (data2),
    .result      (result),
    .zero        (zero),
    .done        (done),
    .err         (err),
    .zflag       (zflag),
    .halted      (halted),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  always_comb begin
    result = 8'h00;
    case (ALUctrlbits)
      3'b000:  result = data1 + data2;
      3'b001:  result = data1 - data2;
      3'b010:  result = data1 & data2;
      3'b011:  result = data1 | data2;
      3'b100:  result = data1 ^ data2;
      default: result = 8'h00;
    endcase
    zero = (result == 8'h00);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_regs();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1 chk($sformatf("reg%0d", i),
             32'(dbg_data), 32'(rm[i]));
    end
  endtask

  task automatic chk_reset();
    chk("rst_ready", 32'(instr_ready), 1);
    chk("rst_ctrl", 32'(ALUctrlbits), 0);
    chk("rst_data1", 32'(data1), 0);
    chk("rst_data2", 32'(data2), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_zflag", 32'(zflag), 0);
    chk("rst_halted", 32'(halted), 0);
    for (int i = 0; i < 4; i++) rm[i] = 8'h00;
    zm = 1'b0;
    sb.delete();
    check_regs();
  endtask

  task automatic load(input logic [1:0] sel,
                      input logic [7:0] val);
    ld_en   = 1'b1;
    ld_sel  = sel;
    ld_data = val;
    rm[sel] = val;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run_instr(input logic [7:0] ins,
                           input logic       ld,
                           input logic [1:0] lsel,
                           input logic [7:0] ldat,
                           input logic       junk);
    logic [2:0] op;
    logic [1:0] rd, rs;
    logic [7:0] a, b, v;
    logic       z;
    sb_t        e;
    int         lat;
    bit         got;
    op = ins[7:5];
    rd = ins[4:3];
    rs = ins[2:1];
    ld_sel  = lsel;
    ld_data = ldat;
    if (ld) begin
      ld_en    = 1'b1;
      rm[lsel] = ldat;
    end
    a = rm[rd];
    b = rm[rs];
    z = zm;
    case (op)
      3'd0:    v = a + b;
      3'd1:    v = a - b;
      3'd2:    v = a & b;
      3'd3:    v = a | b;
      3'd4:    v = a ^ b;
      default: v = b;
    endcase
    if (op <= 3'd4) z = (v == 8'h00);
    instr_valid = 1'b1;
    instr       = ins;
    chk("ready_c0", 32'(instr_ready), 1);
    if (op <= 3'd5) begin
      e.rd  = rd;
      e.val = v;
      e.z   = z;
      sb.push_back(e);
      rm[rd] = v;
      zm     = z;
    end
    @(negedge clk);
    instr_valid = 1'b0;
    ld_en       = junk;
    chk("done_c1", 32'(done), 0);
    chk("ready_c1", 32'(instr_ready), 0);
    @(negedge clk);
    if (op == 3'd6) begin
      chk("err_c2", 32'(err), 1);
      chk("ready_c2", 32'(instr_ready), 1);
      ld_en = 1'b0;
      @(negedge clk);
      chk("err_c3", 32'(err), 0);
      chk("zflag_ill", 32'(zflag), 32'(zm));
      return;
    end
    if (op == 3'd7) begin
      chk("halted_c2", 32'(halted), 1);
      chk("ready_halt", 32'(instr_ready), 0);
      ld_en = 1'b0;
      return;
    end
    if (op <= 3'd4) chk("alu_ctrl", 32'(ALUctrlbits), 32'(op));
    chk("data1", 32'(data1), 32'(a));
    chk("data2", 32'(data2), 32'(b));
    chk("done_c2", 32'(done), 0);
    got = 1'b0;
    lat = 0;
    for (int i = 3; i < 10 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        lat = i;
      end
    end
    chk("done_lat", 32'(lat), 3);
    ld_en = 1'b0;
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      chk("done_c4", 32'(done), 0);
      chk("ready_c4", 32'(instr_ready), 1);
      chk("zflag", 32'(zflag), 32'(e.z));
      dbg_sel = e.rd;
      #1 chk("wb_val", 32'(dbg_data), 32'(e.val));
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 8'h00;
    ld_en       = 1'b0;
    ld_sel      = 2'd0;
    ld_data     = 8'h00;
    dbg_sel     = 2'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_reset();

    load(2'd0, 8'h29);
    load(2'd1, 8'hFF);
    run_instr(8'h62, 1'b0, 2'd0, 8'h00, 1'b0);
    check_regs();

    load(2'd2, 8'h05);
    load(2'd3, 8'h05);
    run_instr(8'h36, 1'b0, 2'd0, 8'h00, 1'b0);
    check_regs();

    load(2'd0, 8'hA5);
    run_instr(8'hA8, 1'b0, 2'd0, 8'h00, 1'b0);
    check_regs();

    load(2'd0, 8'hFF);
    load(2'd1, 8'h02);
    run_instr(8'h02, 1'b0, 2'd0, 8'h00, 1'b0);
    check_regs();

    run_instr(8'h52, 1'b0, 2'd3, 8'h77, 1'b1);
    check_regs();

    run_instr(8'h86, 1'b1, 2'd3, 8'h10, 1'b0);
    check_regs();

    run_instr(8'h8A, 1'b0, 2'd0, 8'h00, 1'b0);
    check_regs();

    run_instr(8'hC0, 1'b0, 2'd0, 8'h00, 1'b0);
    check_regs();
    chk("zflag_after_ill", 32'(zflag), 32'(zm));

    load(2'd0, 8'h03);
    load(2'd1, 8'h04);
    instr_valid = 1'b1;
    instr       = 8'h02;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("exec_ctrl", 32'(ALUctrlbits), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("no_done", 32'(done), 0);
      @(negedge clk);
    end
    chk_reset();

    load(2'd2, 8'h5A);
    run_instr(8'hE0, 1'b0, 2'd0, 8'h00, 1'b0);
    instr_valid = 1'b1;
    instr       = 8'h02;
    ld_en       = 1'b1;
    ld_sel      = 2'd2;
    ld_data     = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("halt_ready", 32'(instr_ready), 0);
      chk("halt_hold", 32'(halted), 1);
    end
    instr_valid = 1'b0;
    ld_en       = 1'b0;
    check_regs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
